prim_sum_seq_ctrl: RTL and testbench

- Sequencing controller for a narrow, shared summation datapath.
- Accepts one request of NumSrc valid-qualified values over a ready/valid handshake and captures it.
- Feeds the captured values NumLanes per cycle through an internal NumLanes-wide sum stage, accumulating across beats.
- Returns the total over a second ready/valid handshake. Used where a full NumSrc-wide combinational sum is too large or too slow.

---
 rtl/prim_sum_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_prim_sum_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prim_sum_seq_ctrl.sv
// prim_sum_seq_ctrl
//
// Sequencing controller for a narrow, shared summation datapath.
// The controller accepts one request of NumSrc valid-qualified values,
// captures it, and then sums NumLanes values per cycle into an
// accumulator. When all beats are consumed, it presents the total on a
// result handshake.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   req_valid_i  request offered
//   req_ready_o  controller can accept a request (IDLE)
//   values_i     [NumSrc-1:0][Width-1:0] input values
//   valid_i      per-value valid bits; invalid values count as 0
//   res_valid_o  result available (DONE)
//   res_ready_i  consumer takes the result
//   sum_value_o  summation result (wrapped, or clamped when Saturate=1)
//   sum_valid_o  at least one captured valid bit was set
//   overflow_o   true sum of valid values >= 2**Width
//   busy_o       controller is in RUN or DONE
module prim_sum_seq_ctrl #(
  parameter int NumSrc   = 32,
  parameter int NumLanes = 8,
  parameter int Width    = 8,
  parameter bit Saturate = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [NumSrc-1:0][Width-1:0]     values_i,
  input  logic [NumSrc-1:0]                valid_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [Width-1:0]                 sum_value_o,
  output logic                             sum_valid_o,
  output logic                             overflow_o,
  output logic                             busy_o
);

  localparam int NumBeats = NumSrc / NumLanes;
  localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int LaneW    = $clog2(NumLanes);
  localparam int IdxW     = BeatW + LaneW;
  localparam int BeatSumW = Width + LaneW;
  // One extra bit holds acc (< 2**Width) plus a full beat sum without loss.
  localparam int AccW     = BeatSumW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state;

  // Capture stage: request data held for the whole run
  logic [NumSrc-1:0][Width-1:0] values_p0;
  logic [NumSrc-1:0]            vld_p0;
  logic [BeatW-1:0]             beat_p0;

  // Accumulate stage
  logic [Width-1:0]             acc_p1;
  logic                         ovf_p1;
  logic                         any_p1;

  logic [IdxW-1:0]              idx;
  logic [BeatSumW-1:0]          beat_sum;
  logic                         beat_any;
  logic [AccW-1:0]              acc_next;
  logic                         ovf_next;
  logic                         any_next;

  function automatic logic [Width-1:0] sat_fn(input logic [Width-1:0] val,
                                              input logic             ovf);
    if (Saturate && ovf) begin
      return '1;
    end
    return val;
  endfunction

  // Lane index is {beat, lane} because NumLanes is a power of two.
  always_comb begin
    idx      = '0;
    beat_sum = '0;
    beat_any = 1'b0;
    for (int l = 0; l < NumLanes; l++) begin
      idx = {beat_p0, LaneW'(l)};
      if (vld_p0[idx]) begin
        beat_sum = beat_sum + BeatSumW'(values_p0[idx]);
      end
      beat_any = beat_any | vld_p0[idx];
    end
    acc_next = AccW'(acc_p1) + AccW'(beat_sum);
    ovf_next = ovf_p1 | (acc_next[AccW-1:Width] != '0);
    any_next = any_p1 | beat_any;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      values_p0   <= '0;
      vld_p0      <= '0;
      beat_p0     <= '0;
      acc_p1      <= '0;
      ovf_p1      <= 1'b0;
      any_p1      <= 1'b0;
      req_ready_o <= 1'b0;
      res_valid_o <= 1'b0;
      sum_value_o <= '0;
      sum_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            values_p0   <= values_i;
            vld_p0      <= valid_i;
            beat_p0     <= '0;
            acc_p1      <= '0;
            ovf_p1      <= 1'b0;
            any_p1      <= 1'b0;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          acc_p1  <= acc_next[Width-1:0];
          ovf_p1  <= ovf_next;
          any_p1  <= any_next;
          beat_p0 <= beat_p0 + 1'b1;
          // Results are registered from the final beat's next-state values,
          // so they appear in the first DONE cycle.
          if (beat_p0 == BeatW'(NumBeats - 1)) begin
            res_valid_o <= 1'b1;
            sum_value_o <= sat_fn(acc_next[Width-1:0], ovf_next);
            sum_valid_o <= any_next;
            overflow_o  <= ovf_next;
            state       <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            sum_value_o <= '0;
            sum_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prim_sum_seq_ctrl.sv
// Testbench for prim_sum_seq_ctrl: a wrapping instance (w) and a saturating
// instance (s), driven by a vector table plus hand-written sequences for
// backpressure and mid-run reset.
module tb_prim_sum_seq_ctrl;
  localparam int NumSrc   = 32;
  localparam int NumLanes = 8;
  localparam int Width    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                         req_valid_w, req_ready_w, res_valid_w, res_ready_w;
  logic                         sum_valid_w, overflow_w, busy_w;
  logic [NumSrc-1:0][Width-1:0] values_w;
  logic [NumSrc-1:0]            valid_w;
  logic [Width-1:0]             sum_w;

  logic                         req_valid_s, req_ready_s, res_valid_s, res_ready_s;
  logic                         sum_valid_s, overflow_s, busy_s;
  logic [NumSrc-1:0][Width-1:0] values_s;
  logic [NumSrc-1:0]            valid_s;
  logic [Width-1:0]             sum_s;

  prim_sum_seq_ctrl #(.NumSrc(NumSrc), .NumLanes(NumLanes), .Width(Width), .Saturate(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_w), .req_ready_o(req_ready_w),
    .values_i(values_w), .valid_i(valid_w),
    .res_valid_o(res_valid_w), .res_ready_i(res_ready_w),
    .sum_value_o(sum_w), .sum_valid_o(sum_valid_w),
    .overflow_o(overflow_w), .busy_o(busy_w)
  );

  prim_sum_seq_ctrl #(.NumSrc(NumSrc), .NumLanes(NumLanes), .Width(Width), .Saturate(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_s), .req_ready_o(req_ready_s),
    .values_i(values_s), .valid_i(valid_s),
    .res_valid_o(res_valid_s), .res_ready_i(res_ready_s),
    .sum_value_o(sum_s), .sum_valid_o(sum_valid_s),
    .overflow_o(overflow_s), .busy_o(busy_s)
  );

  typedef struct {
    bit           sel;      // 0: wrapping instance, 1: saturating instance
    logic [255:0] values;
    logic [31:0]  valid;
    logic [7:0]   exp_sum;
    logic         exp_sv;
    logic         exp_ov;
    string        name;
  } vec_t;

  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] ramp();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k*8 +: 8] = 8'(k);
    return r;
  endfunction

  function automatic logic [255:0] put(input logic [255:0] base, input int idx, input logic [7:0] b);
    logic [255:0] r;
    r = base;
    r[idx*8 +: 8] = b;
    return r;
  endfunction

  task automatic drive_req(input bit sel, input logic [255:0] v, input logic [31:0] vl, input logic rv);
    if (sel) begin
      values_s = v; valid_s = vl; req_valid_s = rv;
    end else begin
      values_w = v; valid_w = vl; req_valid_w = rv;
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 into cycle T+1.
  // Inputs are scrambled afterwards to show they are don't-care.
  task automatic start_req(input bit sel, input logic [255:0] v, input logic [31:0] vl);
    drive_req(sel, v, vl, 1'b1);
    @(posedge clk); #1;
    drive_req(sel, ~v, ~vl, 1'b0);
  endtask

  // From T+1: result must be absent at T+4 and present at T+5.
  task automatic wait_result(input bit sel, input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_busy"}, 32'(sel ? busy_s : busy_w), 32'd1);
    chk({nm, "_early_res_valid"}, 32'(sel ? res_valid_s : res_valid_w), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_res_valid"}, 32'(sel ? res_valid_s : res_valid_w), 32'd1);
  endtask

  task automatic check_out(input bit sel, input string nm, input logic [7:0] es,
                           input logic esv, input logic eov);
    chk({nm, "_sum"}, 32'(sel ? sum_s : sum_w), 32'(es));
    chk({nm, "_sum_valid"}, 32'(sel ? sum_valid_s : sum_valid_w), 32'(esv));
    chk({nm, "_overflow"}, 32'(sel ? overflow_s : overflow_w), 32'(eov));
    chk({nm, "_req_ready_done"}, 32'(sel ? req_ready_s : req_ready_w), 32'd0);
  endtask

  task automatic pop(input bit sel, input string nm);
    if (sel) res_ready_s = 1'b1; else res_ready_w = 1'b1;
    @(posedge clk); #1;
    if (sel) res_ready_s = 1'b0; else res_ready_w = 1'b0;
    chk({nm, "_pop_res_valid"}, 32'(sel ? res_valid_s : res_valid_w), 32'd0);
    chk({nm, "_pop_sum"}, 32'(sel ? sum_s : sum_w), 32'd0);
    chk({nm, "_pop_sum_valid"}, 32'(sel ? sum_valid_s : sum_valid_w), 32'd0);
    chk({nm, "_pop_overflow"}, 32'(sel ? overflow_s : overflow_w), 32'd0);
    chk({nm, "_pop_req_ready"}, 32'(sel ? req_ready_s : req_ready_w), 32'd1);
    chk({nm, "_pop_busy"}, 32'(sel ? busy_s : busy_w), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid_w = 1'b0; res_ready_w = 1'b0; values_w = '0; valid_w = '0;
    req_valid_s = 1'b0; res_ready_s = 1'b0; values_s = '0; valid_s = '0;

    #2;
    chk("rst_req_ready", 32'(req_ready_w), 32'd0);
    chk("rst_res_valid", 32'(res_valid_w), 32'd0);
    chk("rst_busy", 32'(busy_w), 32'd0);
    chk("rst_sum", 32'(sum_w), 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready_w", 32'(req_ready_w), 32'd1);
    chk("post_rst_ready_s", 32'(req_ready_s), 32'd1);

    // 0..31 sum to 496; 496 mod 256 = 0xF0.
    vecs[0] = '{1'b0, ramp(), 32'hFFFF_FFFF, 8'hF0, 1'b1, 1'b1, "ramp_wrap"};
    vecs[1] = '{1'b0, {32{8'h01}}, 32'h5555_5555, 8'd16, 1'b1, 1'b0, "half_ones"};
    vecs[2] = '{1'b0, {32{8'hFF}}, 32'h0, 8'h00, 1'b0, 1'b0, "none_valid"};
    vecs[3] = '{1'b0, put('0, 31, 8'h7F), 32'h8000_0000, 8'h7F, 1'b1, 1'b0, "last_lane"};
    vecs[4] = '{1'b0, put(put('0, 0, 8'h80), 31, 8'h80), 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b1, "wrap_256"};
    vecs[5] = '{1'b1, ramp(), 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b1, "sat_ramp"};
    vecs[6] = '{1'b1, put(put('0, 0, 8'h80), 31, 8'h7F), 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b0, "sat_255"};
    vecs[7] = '{1'b1, put(put('0, 0, 8'h80), 31, 8'h80), 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b1, "sat_256"};
    vecs[8] = '{1'b1, {32{8'hFF}}, 32'h0, 8'h00, 1'b0, 1'b0, "sat_none_valid"};

    for (int i = 0; i < 9; i++) begin
      chk({vecs[i].name, "_req_ready"}, 32'(vecs[i].sel ? req_ready_s : req_ready_w), 32'd1);
      start_req(vecs[i].sel, vecs[i].values, vecs[i].valid);
      wait_result(vecs[i].sel, vecs[i].name);
      check_out(vecs[i].sel, vecs[i].name, vecs[i].exp_sum, vecs[i].exp_sv, vecs[i].exp_ov);
      pop(vecs[i].sel, vecs[i].name);
    end

    // Backpressure: result held 3 cycles while a new request is offered.
    start_req(1'b0, {32{8'h01}}, 32'h5555_5555);
    drive_req(1'b0, {32{8'h33}}, 32'hFFFF_FFFF, 1'b1);
    wait_result(1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      check_out(1'b0, "bp_hold", 8'd16, 1'b1, 1'b0);
      @(posedge clk); #1;
    end
    check_out(1'b0, "bp_last", 8'd16, 1'b1, 1'b0);
    pop(1'b0, "bp");
    @(posedge clk); #1;
    drive_req(1'b0, '0, '0, 1'b0);
    wait_result(1'b0, "bp_next");
    // 32 * 0x33 = 1632 = 0x660.
    check_out(1'b0, "bp_next", 8'h60, 1'b1, 1'b1);
    pop(1'b0, "bp_next");

    // Reset during beat 2 of the ramp request.
    start_req(1'b0, ramp(), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy_w), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_w), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready_w), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid_w), 32'd0);
    chk("mid_rst_sum", 32'(sum_w), 32'd0);
    chk("mid_rst_overflow", 32'(overflow_w), 32'd0);
    chk("mid_rst_sum_valid", 32'(sum_valid_w), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_req_ready", 32'(req_ready_w), 32'd1);
    start_req(1'b0, {32{8'h01}}, 32'h5555_5555);
    wait_result(1'b0, "after_rst");
    check_out(1'b0, "after_rst", 8'd16, 1'b1, 1'b0);
    pop(1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
